// File: rtl/audio_output_spi.sv
// Playback path: accepts signed samples, reduces them to DAC depth in offset-binary and shifts
// a 16-bit frame to a SPI voltage DAC, then pulses LDAC. Define AUDIO_OUTPUT_SPI_ROUND_EN to round.
module audio_output_spi #(
  parameter int unsigned bit_depth    = 12,
  parameter int unsigned target_depth = 16,
  parameter int unsigned clk_div      = 4,
  parameter logic [3:0]  cfg_bits     = 4'b0011
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [target_depth-1:0] i_sample,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic                    o_sclk,
  output logic                    o_mosi,
  output logic                    o_cs_n,
  output logic                    o_ldac_n
);

  localparam int unsigned Shift = target_depth - bit_depth;
  localparam int unsigned CntW  = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(clk_div - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StLatch} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     frame_q, frame_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            ldac_n_q, ldac_n_d;
  logic            ready_q, ready_d;

  // Sample conversion
  logic signed [target_depth-1:0] pre_shift;
  logic [bit_depth-1:0]           d_val;
  logic [bit_depth-1:0]           u_val;
  logic [11:0]                    data_field;
  logic [15:0]                    frame;

`ifdef AUDIO_OUTPUT_SPI_ROUND_EN
  localparam int unsigned RoundAdd = (Shift > 0) ? (1 << (Shift - 1)) : 0;
  logic signed [target_depth:0] sum;
  assign sum = {i_sample[target_depth-1], i_sample} + (target_depth + 1)'(RoundAdd);
  // Adding a non-negative constant can only overflow upward; clamp to positive full scale.
  assign pre_shift = (sum[target_depth] != sum[target_depth-1]) ?
                     {1'b0, {(target_depth - 1){1'b1}}} : sum[target_depth-1:0];
`else
  assign pre_shift = i_sample;
`endif

  // Low bit_depth bits of (pre_shift >>> Shift) are exactly the top bit_depth bits.
  assign d_val = pre_shift[target_depth-1 -: bit_depth];

  always_comb begin
    u_val = d_val;
    u_val[bit_depth-1] = ~d_val[bit_depth-1];
  end

  assign data_field = 12'(u_val) << (12 - bit_depth);
  assign frame      = {cfg_bits, data_field};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      ldac_n_q <= ldac_n_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cs_n_d   = cs_n_q;
    ldac_n_d = ldac_n_q;
    ready_d  = ready_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d = StShift;
          frame_d = frame;
          cnt_d   = '0;
          bit_d   = 4'd15;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = frame[15];
          ready_d = 1'b0;
        end
      end
      StShift: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = StGap;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = frame_q[bit_q - 4'd1];
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntMax) begin
          cnt_d    = '0;
          ldac_n_d = 1'b0;
          state_d  = StLatch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        if (cnt_q == CntMax) begin
          cnt_d    = '0;
          ldac_n_d = 1'b1;
          ready_d  = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_ready  = ready_q;
  assign o_sclk   = sclk_q;
  assign o_mosi   = mosi_q;
  assign o_cs_n   = cs_n_q;
  assign o_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_audio_output_spi.sv
// Self-checking bench for audio_output_spi: directed table, random samples against a
// arithmetic reference model, continuous-valid throughput, mid-frame reset, and an 8-bit build.
module tb_audio_output_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sample;
  logic        valid;
  logic        which;

  logic a_ready, a_sclk, a_mosi, a_cs_n, a_ldac_n;
  logic b_ready, b_sclk, b_mosi, b_cs_n, b_ldac_n;
  logic obs_ready, obs_sclk, obs_mosi, obs_cs_n, obs_ldac_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_output_spi dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (sample),
    .i_valid  (valid & ~which),
    .o_ready  (a_ready),
    .o_sclk   (a_sclk),
    .o_mosi   (a_mosi),
    .o_cs_n   (a_cs_n),
    .o_ldac_n (a_ldac_n)
  );

  audio_output_spi #(
    .bit_depth (8),
    .clk_div   (1)
  ) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sample (sample),
    .i_valid  (valid & which),
    .o_ready  (b_ready),
    .o_sclk   (b_sclk),
    .o_mosi   (b_mosi),
    .o_cs_n   (b_cs_n),
    .o_ldac_n (b_ldac_n)
  );

  assign obs_ready  = which ? b_ready  : a_ready;
  assign obs_sclk   = which ? b_sclk   : a_sclk;
  assign obs_mosi   = which ? b_mosi   : a_mosi;
  assign obs_cs_n   = which ? b_cs_n   : a_cs_n;
  assign obs_ldac_n = which ? b_ldac_n : a_ldac_n;

  // SPI slave: shifts MOSI on each SCLK rise while CS is low, logs frame when CS rises.
  int frame_q[$];
  int pulse_q[$];
  int sh, pc;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (prev_cs && !obs_cs_n) begin
      sh = 0;
      pc = 0;
    end
    if (!obs_cs_n && !prev_sclk && obs_sclk) begin
      sh = ((sh << 1) | int'(obs_mosi)) & 16'hFFFF;
      pc++;
    end
    if (!prev_cs && obs_cs_n) begin
      frame_q.push_back(sh);
      pulse_q.push_back(pc);
    end
    prev_cs   = obs_cs_n;
    prev_sclk = obs_sclk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: scale by powers of two with floor division, then offset by half range.
  function automatic logic [15:0] model(input logic [15:0] s, input int bd);
    int v, shv, d, u;
    shv = 16 - bd;
    v   = int'($signed(s));
`ifdef AUDIO_OUTPUT_SPI_ROUND_EN
    if (shv > 0) begin
      v = v + (1 << (shv - 1));
      if (v > 32767) v = 32767;
    end
`endif
    d = v >>> shv;
    u = (d + (1 << (bd - 1))) & ((1 << bd) - 1);
    return 16'((3 << 12) | (u << (12 - bd)));
  endfunction

  task automatic run_frame(input logic [15:0] s, input logic [15:0] exp, input int cd,
                           input string tag);
    int cs_rise = -1, ldac_first = -1, ldac_cnt = 0, ready_rise = -1, sclk_first = -1;
    chk({tag, " ready_before"}, int'(obs_ready), 1);
    sample = s;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    sample = ~s;
    chk({tag, " cs_fall"}, int'(obs_cs_n), 0);
    chk({tag, " first_mosi"}, int'(obs_mosi), int'(exp[15]));
    for (int n = 0; n < 34 * cd + 4; n++) begin
      if (sclk_first < 0 && obs_sclk) sclk_first = n;
      if (cs_rise < 0 && obs_cs_n) cs_rise = n;
      if (!obs_ldac_n) begin
        if (ldac_first < 0) ldac_first = n;
        ldac_cnt++;
      end
      if (ready_rise < 0 && obs_ready) ready_rise = n;
      @(negedge clk);
    end
    chk({tag, " sclk_first"}, sclk_first, cd);
    chk({tag, " cs_rise"}, cs_rise, 32 * cd);
    chk({tag, " ldac_start"}, ldac_first, 33 * cd);
    chk({tag, " ldac_len"}, ldac_cnt, cd);
    chk({tag, " ready_rise"}, ready_rise, 34 * cd);
    chk({tag, " frames_seen"}, frame_q.size(), 1);
    if (frame_q.size() > 0) begin
      chk({tag, " frame"}, frame_q.pop_front(), int'(exp));
      chk({tag, " pulses"}, pulse_q.pop_front(), 16);
    end
    frame_q.delete();
    pulse_q.delete();
  endtask

  typedef struct {
    logic [15:0] smp;
    logic [15:0] frm;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bad, acc0, acc1, nacc, rlow, lows;
    logic [15:0] rs;
`ifdef AUDIO_OUTPUT_SPI_ROUND_EN
    vecs[0] = '{16'h0008, 16'h3801};
    vecs[1] = '{16'h7FFF, 16'h3FFF};
    vecs[2] = '{16'hFFFF, 16'h3800};
    vecs[3] = '{16'h0000, 16'h3800};
`else
    vecs[0] = '{16'h0000, 16'h3800};
    vecs[1] = '{16'h7FFF, 16'h3FFF};
    vecs[2] = '{16'h8000, 16'h3000};
    vecs[3] = '{16'hFFFF, 16'h37FF};
`endif
    rst_n  = 1'b0;
    valid  = 1'b0;
    which  = 1'b0;
    sample = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", int'(a_ready), 1);
    chk("rst cs_n", int'(a_cs_n), 1);
    rst_n = 1'b1;

    // Idle with no valid
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!a_ready || !a_cs_n || !a_ldac_n || a_sclk || a_mosi) bad++;
    end
    chk("idle hold", bad, 0);

    foreach (vecs[i]) run_frame(vecs[i].smp, vecs[i].frm, 4, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rs = 16'($urandom);
      run_frame(rs, model(rs, 12), 4, $sformatf("rand%0d", i));
    end

    // Continuous valid: accept spacing, ready-low duration, capture isolation
    sample = 16'h4567;
    valid  = 1'b1;
    acc0 = -1; acc1 = -1; nacc = 0; rlow = 0;
    begin
      logic pcs;
      pcs = 1'b1;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (pcs && !a_cs_n) begin
          if (nacc == 0) acc0 = n; else if (nacc == 1) acc1 = n;
          nacc++;
          if (nacc == 2) valid = 1'b0;
        end
        if (acc0 >= 0 && n == acc0 + 50) sample = 16'hA5A5;
        if (acc0 >= 0 && acc1 < 0 && !a_ready) rlow++;
        pcs = a_cs_n;
      end
    end
    chk("stream spacing", acc1 - acc0, 137);
    chk("stream ready_low", rlow, 136);
    chk("stream frames", frame_q.size(), 2);
    if (frame_q.size() == 2) begin
      chk("stream frame0", frame_q.pop_front(), int'(model(16'h4567, 12)));
      chk("stream frame1", frame_q.pop_front(), int'(model(16'hA5A5, 12)));
    end
    frame_q.delete();
    pulse_q.delete();
    repeat (10) @(negedge clk);

    // Asynchronous reset during bit 7
    sample = 16'h1357;
    valid  = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (65) @(negedge clk);
    chk("pre_rst cs_n", int'(a_cs_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async ready", int'(a_ready), 1);
    chk("async sclk", int'(a_sclk), 0);
    chk("async mosi", int'(a_mosi), 0);
    chk("async cs_n", int'(a_cs_n), 1);
    chk("async ldac_n", int'(a_ldac_n), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (!a_ldac_n || !a_cs_n) lows++;
    end
    chk("post_rst quiet", lows, 0);
    frame_q.delete();
    pulse_q.delete();
    run_frame(16'h2468, model(16'h2468, 12), 4, "after_rst");

    // 8-bit, clk_div=1 instance
    which = 1'b1;
    @(negedge clk);
    run_frame(16'h1234, model(16'h1234, 8), 1, "bd8");
    rs = 16'($urandom);
    run_frame(rs, model(rs, 8), 1, "bd8 rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
